// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register file write controller.
package reg_file_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic int unsigned num_regs(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_write_ctrl_if.sv
// Write/clear/read bus of the register file; master drives requests, slave is the file.
interface reg_file_write_ctrl_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   clr_req;
  logic                   busy;
  logic                   clr_done;
  logic [(1<<ADDR_W)-1:0] to_reg;
  logic [ADDR_W-1:0]      rd_addr0;
  logic [DATA_W-1:0]      rd_data0;
  logic [ADDR_W-1:0]      rd_addr1;
  logic [DATA_W-1:0]      rd_data1;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req, rd_addr0, rd_addr1,
    input  wr_ready, busy, clr_done, to_reg, rd_data0, rd_data1
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req, rd_addr0, rd_addr1,
    output wr_ready, busy, clr_done, to_reg, rd_data0, rd_data1
  );
endinterface

// File: rtl/reg_file_write_ctrl_wr_addr_decoder.sv
// Combinational address-to-one-hot decoder with enable.
module wr_addr_decoder #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      d,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] q
);
  always_comb begin
    q = '0;
    if (en) q[d] = 1'b1;
  end
endmodule

// File: rtl/reg_file_write_ctrl.sv
// Register file with staged handshaked write port, one-hot strobe and sequenced clear.
// Optional macro REG_FILE_BYPASS_EN forwards the staged entry to matching read ports.
module reg_file_write_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_file_write_ctrl_if.slave bus
);
  localparam int unsigned NUM_REGS = num_regs(ADDR_W);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_stg_vld, w_stg_vld_nxt;
  logic [ADDR_W-1:0]   r_stg_addr, w_stg_addr_nxt;
  logic [DATA_W-1:0]   r_stg_data, w_stg_data_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_strobe;
  logic                w_wr_ready, w_busy, w_clr_done;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_stg_vld_nxt  = 1'b0;
    w_stg_addr_nxt = r_stg_addr;
    w_stg_data_nxt = r_stg_data;
    w_wr_ready     = 1'b0;
    w_busy         = 1'b0;
    w_clr_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_ready = ~bus.clr_req;
        if (bus.clr_req) begin
          w_state_nxt = CLEAR;
        end else if (bus.wr_valid) begin
          w_stg_vld_nxt  = 1'b1;
          w_stg_addr_nxt = bus.wr_addr;
          w_stg_data_nxt = bus.wr_data;
        end
      end
      CLEAR: begin
        w_busy         = 1'b1;
        w_stg_vld_nxt  = 1'b1;
        w_stg_addr_nxt = r_cnt;
        w_stg_data_nxt = '0;
        if (r_cnt == '1) begin
          w_clr_done  = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_stg_vld  <= 1'b0;
      r_stg_addr <= '0;
      r_stg_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stg_vld  <= w_stg_vld_nxt;
      r_stg_addr <= w_stg_addr_nxt;
      r_stg_data <= w_stg_data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_stg_vld) begin
      r_regs[r_stg_addr] <= r_stg_data;
    end
  end

  wr_addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .d  (r_stg_addr),
    .en (r_stg_vld),
    .q  (w_strobe)
  );

`ifdef REG_FILE_BYPASS_EN
  assign bus.rd_data0 = (r_stg_vld && r_stg_addr == bus.rd_addr0) ? r_stg_data : r_regs[bus.rd_addr0];
  assign bus.rd_data1 = (r_stg_vld && r_stg_addr == bus.rd_addr1) ? r_stg_data : r_regs[bus.rd_addr1];
`else
  assign bus.rd_data0 = r_regs[bus.rd_addr0];
  assign bus.rd_data1 = r_regs[bus.rd_addr1];
`endif

  assign bus.wr_ready = w_wr_ready;
  assign bus.busy     = w_busy;
  assign bus.clr_done = w_clr_done;
  assign bus.to_reg   = w_strobe;
endmodule

// File: tb/tb_reg_file_write_ctrl.sv
// Directed bench for reg_file_write_ctrl with a small reference model for the random phase.
module tb_reg_file_write_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_write_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  reg_file_write_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] m_regs [8];
  logic       m_vld;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] e_rd;

  initial begin
    reset        = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd2;
    bus.wr_data  = 8'h77;
    bus.clr_req  = 1'b0;
    bus.rd_addr0 = 3'd2;
    bus.rd_addr1 = 3'd5;

    // 1: reset with a write pending
    tick();
    tick();
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    chk("rst_to_reg", 32'(bus.to_reg), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rd0", 32'(bus.rd_data0), 32'h00);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    tick();
    chk("rst_no_commit", 32'(bus.rd_data0), 32'h00);

    // 2: single write 5 <= A5
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 8'hA5; bus.rd_addr0 = 3'd5;
    #1;
    chk("w5_ready", 32'(bus.wr_ready), 32'h1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("w5_to_reg", 32'(bus.to_reg), 32'h20);
`ifdef REG_FILE_BYPASS_EN
    chk("w5_rd_early", 32'(bus.rd_data0), 32'hA5);
`else
    chk("w5_rd_early", 32'(bus.rd_data0), 32'h00);
`endif
    tick();
    chk("w5_to_reg_off", 32'(bus.to_reg), 32'h00);
    chk("w5_rd", 32'(bus.rd_data0), 32'hA5);

    // 3: back-to-back writes to entry 3
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h11; bus.rd_addr1 = 3'd3;
    tick();
    bus.wr_data = 8'h22;
    #1;
    chk("b2b_pulse1", 32'(bus.to_reg), 32'h08);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("b2b_pulse2", 32'(bus.to_reg), 32'h08);
    tick();
    chk("b2b_rd", 32'(bus.rd_data1), 32'h22);
    chk("b2b_idle", 32'(bus.to_reg), 32'h00);

    // 4: fill all entries, then clear with a competing write
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = 8'(8'h11 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    chk("fill_last", 32'(bus.to_reg), 32'h80);
    tick();
    bus.rd_addr0 = 3'd6;
    #1;
    chk("fill_rd6", 32'(bus.rd_data0), 32'h17);
    bus.clr_req = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'hFF;
    #1;
    chk("clr_refuse", 32'(bus.wr_ready), 32'h0);
    tick();
    bus.clr_req = 1'b0; bus.wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("clr_busy%0d", k), 32'(bus.busy), 32'h1);
      chk($sformatf("clr_ready%0d", k), 32'(bus.wr_ready), 32'h0);
      chk($sformatf("clr_done%0d", k), 32'(bus.clr_done), (k == 7) ? 32'h1 : 32'h0);
      chk($sformatf("clr_to_reg%0d", k), 32'(bus.to_reg), (k == 0) ? 32'h0 : (32'h1 << (k - 1)));
      tick();
    end
    chk("clr_end_busy", 32'(bus.busy), 32'h0);
    chk("clr_end_done", 32'(bus.clr_done), 32'h0);
    chk("clr_end_to_reg", 32'(bus.to_reg), 32'h80);
    tick();
    chk("clr_final_to_reg", 32'(bus.to_reg), 32'h00);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr0 = 3'(i);
      #1;
      chk($sformatf("clr_rd%0d", i), 32'(bus.rd_data0), 32'h00);
    end

    // 5: reset during the third clear cycle
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h5A;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    bus.rd_addr0 = 3'd2;
    #1;
    chk("rc_pre", 32'(bus.rd_data0), 32'h5A);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    #1;
    chk("rc_busy", 32'(bus.busy), 32'h1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rc_busy_off", 32'(bus.busy), 32'h0);
    chk("rc_done", 32'(bus.clr_done), 32'h0);
    chk("rc_to_reg", 32'(bus.to_reg), 32'h00);
    chk("rc_rd2", 32'(bus.rd_data0), 32'h00);
    reset = 1'b0;
    #1;
    chk("rc_ready", 32'(bus.wr_ready), 32'h1);
    tick();
    chk("rc_idle_busy", 32'(bus.busy), 32'h0);
    chk("rc_idle_done", 32'(bus.clr_done), 32'h0);
    chk("rc_idle_to_reg", 32'(bus.to_reg), 32'h00);

    // 6: random traffic against a model
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_vld = 1'b0; m_addr = 3'd0; m_data = 8'h00;
    for (int n = 0; n < 60; n++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = 3'($urandom_range(0, 7));
      bus.wr_data  = 8'($urandom);
      bus.rd_addr0 = 3'($urandom_range(0, 7));
      bus.rd_addr1 = 3'($urandom_range(0, 7));
      #1;
      chk("rnd_ready", 32'(bus.wr_ready), 32'h1);
      chk("rnd_to_reg", 32'(bus.to_reg), m_vld ? (32'h1 << m_addr) : 32'h0);
      chk("rnd_onehot", 32'($countones(bus.to_reg) <= 1), 32'h1);
      e_rd = m_regs[bus.rd_addr0];
`ifdef REG_FILE_BYPASS_EN
      if (m_vld && m_addr == bus.rd_addr0) e_rd = m_data;
`endif
      chk("rnd_rd0", 32'(bus.rd_data0), 32'(e_rd));
      e_rd = m_regs[bus.rd_addr1];
`ifdef REG_FILE_BYPASS_EN
      if (m_vld && m_addr == bus.rd_addr1) e_rd = m_data;
`endif
      chk("rnd_rd1", 32'(bus.rd_data1), 32'(e_rd));
      @(posedge clk);
      if (m_vld) m_regs[m_addr] = m_data;
      m_vld  = bus.wr_valid;
      m_addr = bus.wr_addr;
      m_data = bus.wr_data;
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
